// File: rtl/rx_align_ctrl.sv
// -----------------------------------------------------------------------------
// rx_align_ctrl
//   Byte-alignment and link-lock controller for the PHY RX serial-to-parallel
//   path. It hunts the MSB-first serial stream for the COM symbol, fixes the
//   byte phase on the first COM and declares lock after LOCK_COUNT consecutive
//   COMs on that phase. While locked it delivers aligned data bytes with a
//   valid flag. Lock is dropped, and hunting restarts, when TIMEOUT_BYTES
//   consecutive non-COM bytes arrive.
//
// Optional feature macro: RX_ALIGN_STATS_EN
//   Adds relock_cnt (saturating count of lock losses and aborted lock
//   attempts) and lock_err (1-cycle pulse on each of those events).
//
// Ports
//   clk_8f      in   1         bit clock, all logic on posedge
//   reset       in   1         synchronous, active-low reset
//   data_in     in   1         serial data, one bit per clock, MSB first
//   data_out    out  8         aligned byte (updated on LOCKED boundaries)
//   valid_out   out  1         1-cycle pulse: data_out holds a non-COM byte
//   byte_strobe out  1         1-cycle pulse at each aligned byte boundary
//   bc_counter  out  BC_CNT_W  COMs counted since phase fix, saturating
//   active      out  1         link locked
//   state       out  2         00 HUNT, 01 CHECK, 10 LOCKED
//   relock_cnt  out  8         (RX_ALIGN_STATS_EN) lock-loss/abort count
//   lock_err    out  1         (RX_ALIGN_STATS_EN) lock-loss/abort pulse
// -----------------------------------------------------------------------------
module rx_align_ctrl #(
   parameter logic [7:0]  COM_SYMBOL    = 8'hBC,
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned TIMEOUT_BYTES = 64,
   parameter int unsigned BC_CNT_W      = 4
) (
   input  logic                clk_8f,
   input  logic                reset,
   input  logic                data_in,
   output logic [7:0]          data_out,
   output logic                valid_out,
   output logic                byte_strobe,
   output logic [BC_CNT_W-1:0] bc_counter,
   output logic                active,
   output logic [1:0]          state
`ifdef RX_ALIGN_STATS_EN
   ,
   output logic [7:0]          relock_cnt,
   output logic                lock_err
`endif
);

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      CHECK  = 2'b01,
      LOCKED = 2'b10
   } state_t;

   localparam int unsigned           IDLE_W     = $clog2(TIMEOUT_BYTES + 1);
   localparam logic [IDLE_W-1:0]     IDLE_LIMIT = IDLE_W'(TIMEOUT_BYTES);
   localparam logic [BC_CNT_W-1:0]   LOCK_LIMIT = BC_CNT_W'(LOCK_COUNT);
   localparam logic [BC_CNT_W-1:0]   BC_MAX     = '1;

   state_t              st;
   logic [6:0]          sr;        // only the 7 newest bits are ever needed
   logic [7:0]          nsr;
   logic [2:0]          bit_cnt;
   logic [IDLE_W-1:0]   idle_cnt;
   logic [IDLE_W-1:0]   idle_nxt;
   logic [BC_CNT_W-1:0] bc_inc;
   logic                is_com;
   logic                at_boundary;

   // Byte as it stands once this edge samples data_in.
   assign nsr         = {sr, data_in};
   assign is_com      = (nsr == COM_SYMBOL);
   assign bc_inc      = (bc_counter == BC_MAX) ? bc_counter : bc_counter + 1'b1;
   assign idle_nxt    = idle_cnt + 1'b1;
   // Outside HUNT the phase is fixed; the 8th bit of a byte lands at bit_cnt 7.
   assign at_boundary = (bit_cnt == 3'd7);
   assign state       = st;

`ifdef RX_ALIGN_STATS_EN
   logic [7:0] relock_inc;
   assign relock_inc = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
`endif

   // NOTE: every register, including the outputs, is written only here with
   // non-blocking assignments, so all outputs change together on the edge
   // that samples a byte's 8th bit and no ordering races exist between them.
   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         st          <= HUNT;
         sr          <= '0;
         bit_cnt     <= '0;
         idle_cnt    <= '0;
         data_out    <= '0;
         valid_out   <= 1'b0;
         byte_strobe <= 1'b0;
         bc_counter  <= '0;
         active      <= 1'b0;
`ifdef RX_ALIGN_STATS_EN
         relock_cnt  <= '0;
         lock_err    <= 1'b0;
`endif
      end else begin
         sr      <= nsr[6:0];
         bit_cnt <= bit_cnt + 3'd1;   // wraps 7 -> 0 on its own

         // NOTE: pulse outputs default low each cycle and are raised only in
         // the boundary branches below, giving exactly one-cycle pulses.
         valid_out   <= 1'b0;
         byte_strobe <= 1'b0;
`ifdef RX_ALIGN_STATS_EN
         lock_err    <= 1'b0;
`endif

         case (st)
            HUNT: begin
               // COM's MSB is 1, so the cleared shifter can never match
               // before 8 fresh bits have arrived.
               if (is_com) begin
                  st          <= CHECK;
                  bit_cnt     <= '0;
                  bc_counter  <= BC_CNT_W'(1);
                  byte_strobe <= 1'b1;
               end
            end

            CHECK: begin
               if (at_boundary) begin
                  byte_strobe <= 1'b1;
                  if (is_com) begin
                     bc_counter <= bc_inc;
                     // >= rather than == so LOCK_COUNT 1 still locks on the
                     // first COM seen here (count is already 1 on entry).
                     if (bc_inc >= LOCK_LIMIT) begin
                        st       <= LOCKED;
                        active   <= 1'b1;
                        idle_cnt <= '0;
                     end
                  end else begin
                     st         <= HUNT;
                     bc_counter <= '0;
`ifdef RX_ALIGN_STATS_EN
                     relock_cnt <= relock_inc;
                     lock_err   <= 1'b1;
`endif
                  end
               end
            end

            LOCKED: begin
               if (at_boundary) begin
                  byte_strobe <= 1'b1;
                  data_out    <= nsr;
                  if (is_com) begin
                     idle_cnt   <= '0;
                     bc_counter <= bc_inc;
                  end else begin
                     // The byte that times the link out is still delivered.
                     valid_out <= 1'b1;
                     idle_cnt  <= idle_nxt;
                     if (idle_nxt == IDLE_LIMIT) begin
                        st         <= HUNT;
                        active     <= 1'b0;
                        bc_counter <= '0;
`ifdef RX_ALIGN_STATS_EN
                        relock_cnt <= relock_inc;
                        lock_err   <= 1'b1;
`endif
                     end
                  end
               end
            end

            default: st <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_align_ctrl
//   Self-checking bench for rx_align_ctrl. Bytes are shifted in MSB first on
//   the falling edge; whenever a byte is expected to produce a boundary, the
//   expected output set and the cycle it must appear on are queued. A monitor
//   samples 1 time unit after every rising edge and either pops and compares
//   the queued entry or requires the pulse outputs to be idle.
// -----------------------------------------------------------------------------
module tb_rx_align_ctrl;

   localparam logic [7:0] COM = 8'hBC;
   localparam logic [1:0] S_HUNT   = 2'b00;
   localparam logic [1:0] S_CHECK  = 2'b01;
   localparam logic [1:0] S_LOCKED = 2'b10;
`ifdef RX_ALIGN_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk_8f  = 1'b0;
   logic       reset   = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic [3:0] bc_counter;
   logic       active;
   logic [1:0] state;
   logic       lerr_obs;

   always #5 clk_8f = ~clk_8f;

`ifdef RX_ALIGN_STATS_EN
   logic [7:0] relock_cnt;
   logic       lock_err;
   assign lerr_obs = lock_err;
`else
   assign lerr_obs = 1'b0;
`endif

   rx_align_ctrl dut (
      .clk_8f      (clk_8f),
      .reset       (reset),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .bc_counter  (bc_counter),
      .active      (active),
      .state       (state)
`ifdef RX_ALIGN_STATS_EN
      ,
      .relock_cnt  (relock_cnt),
      .lock_err    (lock_err)
`endif
   );

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       valid;
      logic       act;
      logic [1:0] st;
      logic [3:0] bc;
      logic       lerr;
   } exp_t;

   typedef struct {
      logic [7:0] b;
      logic [1:0] st;
      logic [3:0] bc;
      logic       act;
      logic       valid;
      logic [7:0] data;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[9];
   int   n_checks     = 0;
   int   n_errors     = 0;
   int   cyc          = 0;
   int   valid_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %h required %h", name, cyc, act, req);
      end
   endtask

   // {lock_err, data_out, valid_out, byte_strobe, active, state, bc_counter}
   function automatic logic [31:0] pack(input logic [7:0] d, input logic v, input logic s,
                                        input logic a, input logic [1:0] st,
                                        input logic [3:0] bc, input logic le);
      return {14'd0, le, d, v, s, a, st, bc};
   endfunction

   task automatic monitor();
      exp_t e;
      forever begin
         @(posedge clk_8f);
         #1;
         cyc++;
         if (valid_out === 1'b1) valid_pulses++;
         if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            check("boundary",
                  pack(data_out, valid_out, byte_strobe, active, state, bc_counter, lerr_obs),
                  pack(e.data, e.valid, 1'b1, e.act, e.st, e.bc, e.lerr & STATS));
         end else begin
            check("between_bytes", {29'd0, valid_out, byte_strobe, lerr_obs}, 32'd0);
         end
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk_8f);
      data_in = b;
   endtask

   // Shifts one byte; when expect_it is set, queues the outputs that must
   // appear on the edge sampling its last bit.
   task automatic send_byte(input logic [7:0] b, input bit expect_it, input logic [1:0] st,
                            input logic [3:0] bc, input logic act, input logic v,
                            input logic [7:0] d, input logic le);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk_8f);
         if (i == 0 && expect_it) sb_q.push_back('{cyc + 1, d, v, act, st, bc, le});
         data_in = b[i];
      end
   endtask

   task automatic flush(input string name);
      repeat (2) @(negedge clk_8f);
      check(name, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk_8f);
      reset   = 1'b0;
      data_in = 1'b0;
      repeat (n) @(negedge clk_8f);
      check("reset_outputs",
            pack(data_out, valid_out, byte_strobe, active, state, bc_counter, lerr_obs), 32'd0);
`ifdef RX_ALIGN_STATS_EN
      check("reset_relock_cnt", 32'(relock_cnt), 32'd0);
`endif
      reset = 1'b1;
   endtask

   task automatic lock_link();
      send_byte(COM, 1, S_CHECK,  4'd1, 0, 0, 8'h00, 0);
      send_byte(COM, 1, S_CHECK,  4'd2, 0, 0, 8'h00, 0);
      send_byte(COM, 1, S_CHECK,  4'd3, 0, 0, 8'h00, 0);
      send_byte(COM, 1, S_LOCKED, 4'd4, 1, 0, 8'h00, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] bc;
      logic [7:0] rb;
      int         vp0;

      fork
         monitor();
      join_none

      // Lock sequence followed by a few locked bytes, incl. COMs and data.
      tbl = '{
         '{COM,   S_CHECK,  4'd1, 1'b0, 1'b0, 8'h00},
         '{COM,   S_CHECK,  4'd2, 1'b0, 1'b0, 8'h00},
         '{COM,   S_CHECK,  4'd3, 1'b0, 1'b0, 8'h00},
         '{COM,   S_LOCKED, 4'd4, 1'b1, 1'b0, 8'h00},
         '{8'hA5, S_LOCKED, 4'd4, 1'b1, 1'b1, 8'hA5},
         '{COM,   S_LOCKED, 4'd5, 1'b1, 1'b0, COM},
         '{8'h00, S_LOCKED, 4'd5, 1'b1, 1'b1, 8'h00},
         '{8'hFF, S_LOCKED, 4'd5, 1'b1, 1'b1, 8'hFF},
         '{COM,   S_LOCKED, 4'd6, 1'b1, 1'b0, COM}
      };

      // T1 + table: reset 5 cycles, lock on 4 COMs, then locked traffic.
      do_reset(5);
      for (int i = 0; i < 9; i++)
         send_byte(tbl[i].b, 1, tbl[i].st, tbl[i].bc, tbl[i].act, tbl[i].valid, tbl[i].data, 0);

      // T5: alternate 3C / COM for 200 bytes; counter saturates, no timeout.
      bc  = 4'd6;
      vp0 = valid_pulses;
      for (int i = 0; i < 200; i++) begin
         if (i % 2 == 0) begin
            send_byte(8'h3C, 1, S_LOCKED, bc, 1, 1, 8'h3C, 0);
         end else begin
            if (bc != 4'hF) bc = bc + 4'd1;
            send_byte(COM, 1, S_LOCKED, bc, 1, 0, COM, 0);
         end
      end
      flush("t5_queue_drained");
      check("t5_valid_pulses", 32'(valid_pulses - vp0), 32'd100);
      check("t5_bc_saturated", 32'(bc_counter), 32'd15);

      // T2: three junk bits shift the phase; data byte 8 cycles after lock.
      do_reset(2);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      lock_link();
      send_byte(8'hA5, 1, S_LOCKED, 4'd4, 1, 1, 8'hA5, 0);
      flush("t2_queue_drained");

      // T3: three COMs then a non-COM aborts the lock attempt.
      do_reset(2);
      send_byte(COM,   1, S_CHECK, 4'd1, 0, 0, 8'h00, 0);
      send_byte(COM,   1, S_CHECK, 4'd2, 0, 0, 8'h00, 0);
      send_byte(COM,   1, S_CHECK, 4'd3, 0, 0, 8'h00, 0);
      send_byte(8'h55, 1, S_HUNT,  4'd0, 0, 0, 8'h00, 1);
      send_byte(8'h00, 0, S_HUNT,  4'd0, 0, 0, 8'h00, 0);
      send_byte(8'h00, 0, S_HUNT,  4'd0, 0, 0, 8'h00, 0);
      flush("t3_queue_drained");
      check("t3_state_hunt", {30'd0, state}, {30'd0, S_HUNT});
`ifdef RX_ALIGN_STATS_EN
      check("t3_relock_cnt", 32'(relock_cnt), 32'd1);
`endif

      // T4: 64 non-COM bytes time the link out; a trailing COM re-fixes phase.
      do_reset(2);
      lock_link();
      vp0 = valid_pulses;
      rb  = 8'h00;
      for (int i = 0; i < 64; i++) begin
         do rb = 8'($urandom_range(0, 255)); while (rb == COM);
         if (i < 63) send_byte(rb, 1, S_LOCKED, 4'd4, 1, 1, rb, 0);
         else        send_byte(rb, 1, S_HUNT,   4'd0, 0, 1, rb, 1);
      end
      flush("t4_queue_drained");
      check("t4_valid_pulses", 32'(valid_pulses - vp0), 32'd64);
      check("t4_state_active", {29'd0, active, state}, {29'd0, 1'b0, S_HUNT});
`ifdef RX_ALIGN_STATS_EN
      check("t4_relock_cnt", 32'(relock_cnt), 32'd1);
`endif
      send_byte(COM, 1, S_CHECK, 4'd1, 0, 0, rb, 0);
      flush("t4_rehunt_drained");

      // T6: reset mid-byte while locked, then relock at T1 latency.
      do_reset(2);
      lock_link();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      do_reset(1);
      lock_link();
      flush("t6_queue_drained");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
